// File: rtl/pool_pkg.sv
// Shared types and sizing for the 2x2 pooling window feeder.
package pool_pkg;

  localparam int DATA_W   = 16;
  localparam int MAX_COLS = 32;
  localparam int DIM_W    = $clog2(MAX_COLS) + 1;
  localparam int ADDR_W   = $clog2(MAX_COLS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROW_TOP = 2'd1,
    ROW_BOT = 2'd2,
    DRAIN   = 2'd3
  } pool_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] ch1;
    logic [DATA_W-1:0] ch2;
    logic [DATA_W-1:0] ch3;
    logic [DATA_W-1:0] ch4;
  } pool_win_t;

endpackage

// File: rtl/pool_line_buffer.sv
// One-row line buffer: single write port, asynchronous read, contents never reset.
module pool_line_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pool_window_feeder.sv
// Streams a raster feature map into non-overlapping 2x2 windows for the max pooler.
// Optional POOL_ODD_PAD_EN: zero-pad odd last column/row instead of dropping them.
import pool_pkg::*;

module pool_window_feeder (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_cols,
  input  logic [DIM_W-1:0]  cfg_rows,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [DATA_W-1:0] win_ch1,
  output logic [DATA_W-1:0] win_ch2,
  output logic [DATA_W-1:0] win_ch3,
  output logic [DATA_W-1:0] win_ch4,
  output logic              busy,
  output logic              frame_done
);

`ifdef POOL_ODD_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  pool_state_t       state, state_nxt;
  logic [DIM_W-1:0]  cols_q, rows_q, col, row;
  logic [DATA_W-1:0] pend_top, pend_bot;
  logic [DATA_W-1:0] lb_rd, top_px, bot_px;
  pool_win_t         win;
  logic              win_valid_q;
  logic              accept, last_col, last_row, pad_row, emit, next_is_pad_row;

  pool_line_buffer #(
    .DATA_W(DATA_W),
    .DEPTH (MAX_COLS),
    .ADDR_W(ADDR_W)
  ) u_line_buffer (
    .clk    (clk),
    .wr_en  (accept && (state == ROW_TOP)),
    .wr_addr(col[ADDR_W-1:0]),
    .wr_data(in_data),
    .rd_addr(col[ADDR_W-1:0]),
    .rd_data(lb_rd)
  );

  assign accept          = in_valid && in_ready;
  assign last_col        = (col == cols_q - DIM_W'(1));
  assign last_row        = (row == rows_q - DIM_W'(1));
  assign next_is_pad_row = PAD_EN && (DIM_W'(row + DIM_W'(2)) == rows_q);

  // An even-indexed row seen in ROW_BOT is the padded last row: the pixel is the top half.
`ifdef POOL_ODD_PAD_EN
  assign pad_row = (state == ROW_BOT) && !row[0];
  assign emit    = accept && (state == ROW_BOT) && (col[0] || last_col);
`else
  assign pad_row = 1'b0;
  assign emit    = accept && (state == ROW_BOT) && col[0];
`endif

  assign top_px = pad_row ? in_data : lb_rd;
  assign bot_px = pad_row ? '0 : in_data;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (PAD_EN && (cfg_rows == DIM_W'(1))) ? ROW_BOT : ROW_TOP;
      end
      ROW_TOP: begin
        if (accept && last_col) state_nxt = last_row ? DRAIN : ROW_BOT;
      end
      ROW_BOT: begin
        if (accept && last_col) begin
          if (last_row)             state_nxt = DRAIN;
          else if (next_is_pad_row) state_nxt = ROW_BOT;
          else                      state_nxt = ROW_TOP;
        end
      end
      DRAIN: begin
        if (!win_valid_q) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    in_ready   = ((state == ROW_TOP) || (state == ROW_BOT)) && (!win_valid_q || win_ready);
    frame_done = (state == DRAIN) && !win_valid_q;
  end

  // Control and output window registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cols_q      <= '0;
      rows_q      <= '0;
      col         <= '0;
      row         <= '0;
      win_valid_q <= 1'b0;
      win         <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        cols_q <= cfg_cols;
        rows_q <= cfg_rows;
        col    <= '0;
        row    <= '0;
      end else if (accept) begin
        if (last_col) begin
          col <= '0;
          row <= row + DIM_W'(1);
        end else begin
          col <= col + DIM_W'(1);
        end
      end

      if (emit)                          win_valid_q <= 1'b1;
      else if (win_valid_q && win_ready) win_valid_q <= 1'b0;

      if (emit) begin
        if (col[0]) win <= '{ch1: pend_top, ch2: top_px, ch3: pend_bot, ch4: bot_px};
        else        win <= '{ch1: top_px, ch2: '0, ch3: bot_px, ch4: '0};
      end
    end
  end

  // Left half of the window under construction; data only, no reset needed
  always_ff @(posedge clk) begin
    if (accept && (state == ROW_BOT) && !col[0]) begin
      pend_top <= top_px;
      pend_bot <= bot_px;
    end
  end

  assign win_valid = win_valid_q;
  assign win_ch1   = win.ch1;
  assign win_ch2   = win.ch2;
  assign win_ch3   = win.ch3;
  assign win_ch4   = win.ch4;

endmodule

// File: tb/tb_pool_window_feeder.sv
// Scoreboard bench for pool_window_feeder; expectations follow POOL_ODD_PAD_EN when defined.
`timescale 1ns/1ps
module tb_pool_window_feeder;
  import pool_pkg::*;

`ifdef POOL_ODD_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [DIM_W-1:0]  cfg_cols = '0;
  logic [DIM_W-1:0]  cfg_rows = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              win_valid;
  logic              win_ready = 1'b1;
  logic [DATA_W-1:0] win_ch1, win_ch2, win_ch3, win_ch4;
  logic              busy;
  logic              frame_done;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [15:0] pix[64];
  int          fd_cnt = 0;
  bit          stall_en = 1'b0;
  int          hold = 0;

  pool_window_feeder dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_cols  (cfg_cols),
    .cfg_rows  (cfg_rows),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_ch1   (win_ch1),
    .win_ch2   (win_ch2),
    .win_ch3   (win_ch3),
    .win_ch4   (win_ch4),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  // Downstream model: optional 3-cycle back-pressure per window, scoreboard pop on handshake
  always @(negedge clk) begin
    if (rst) begin
      win_ready = 1'b1;
      hold = 0;
    end else begin
      if (stall_en && win_valid && hold < 3) begin
        win_ready = 1'b0;
        hold++;
      end else begin
        win_ready = 1'b1;
      end
      #1;
      if (win_valid && !win_ready) check("in_ready_held", 64'(in_ready), 64'd0);
      if (win_valid && win_ready) begin
        hold = 0;
        if (exp_q.size() == 0) check("win_extra", 64'd1, 64'd0);
        else check("win", {win_ch1, win_ch2, win_ch3, win_ch4}, exp_q.pop_front());
      end
      if (frame_done) fd_cnt++;
    end
  end

  function automatic logic [15:0] pv(input int r, input int c, input int cols, input int rows);
    if (r < rows && c < cols) return pix[r*cols + c];
    return 16'd0;
  endfunction

  function automatic int push_model(input int cols, input int rows);
    int nr, nc, n;
    nr = PAD ? (rows + 1) / 2 : rows / 2;
    nc = PAD ? (cols + 1) / 2 : cols / 2;
    n  = 0;
    for (int wr = 0; wr < nr; wr++)
      for (int wc = 0; wc < nc; wc++) begin
        exp_q.push_back({pv(2*wr, 2*wc, cols, rows), pv(2*wr, 2*wc+1, cols, rows),
                         pv(2*wr+1, 2*wc, cols, rows), pv(2*wr+1, 2*wc+1, cols, rows)});
        n++;
      end
    return n;
  endfunction

  task automatic pulse_start(input int cols, input int rows);
    start = 1'b1;
    cfg_cols = DIM_W'(cols);
    cfg_rows = DIM_W'(rows);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk); #2;
    while (!in_ready) begin
      n++;
      if (n > 500) begin
        check("send_timeout", 64'(in_ready), 64'd1);
        summary();
        $fatal(1, "in_ready never asserted");
      end
      @(negedge clk); #2;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int cols, input int rows, input bit stall);
    int fd0, nexp, n;
    stall_en = stall;
    fd0  = fd_cnt;
    nexp = push_model(cols, rows);
    pulse_start(cols, rows);
    check("busy_after_start", 64'(busy), 64'd1);
    for (int i = 0; i < cols*rows; i++) send(pix[i]);
    if (nexp == 0) begin
      @(negedge clk); #1;
      check("frame_done_next_cycle", 64'(frame_done), 64'd1);
    end
    n = 0;
    while (fd_cnt == fd0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("frame_done_count", 64'(fd_cnt - fd0), 64'd1);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    check("in_ready_idle", 64'(in_ready), 64'd0);
    stall_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_win_valid", 64'(win_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_win_data", {win_ch1, win_ch2, win_ch3, win_ch4}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) pix[i] = 16'(i);
    run_frame(4, 4, 1'b0);
    run_frame(4, 4, 1'b1);

    for (int i = 0; i < 15; i++) pix[i] = 16'(i);
    run_frame(5, 3, 1'b0);

    for (int i = 0; i < 42; i++) pix[i] = 16'($urandom_range(0, 65535));
    run_frame(7, 6, 1'b1);

    // Mid-frame start is ignored; reset abandons the frame
    fd0 = fd_cnt;
    exp_q.push_back({16'd0, 16'd1, 16'd4, 16'd5});
    pulse_start(4, 4);
    for (int i = 0; i < 3; i++) send(16'(i));
    start = 1'b1;
    cfg_cols = DIM_W'(2);
    cfg_rows = DIM_W'(2);
    send(16'd3);
    start = 1'b0;
    for (int i = 4; i < 7; i++) send(16'(i));
    repeat (2) @(posedge clk);
    #1;
    check("midframe_scoreboard", 64'(exp_q.size()), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_win_valid", 64'(win_valid), 64'd0);
    check("mid_rst_win_data", {win_ch1, win_ch2, win_ch3, win_ch4}, 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_rst_no_frame_done", 64'(fd_cnt - fd0), 64'd0);
    exp_q.delete();

    pix[0] = 16'd7; pix[1] = 16'd9; pix[2] = 16'd3; pix[3] = 16'd1;
    run_frame(2, 2, 1'b0);

    for (int i = 0; i < 4; i++) pix[i] = 16'(100 + i);
    run_frame(1, 4, 1'b0);

    summary();
    $finish;
  end

endmodule
